// File: rtl/framebuffer_pkg.sv
// Shared types for the frame-buffer scheduler: controller command encoding,
// buffer index type and the buffer base address helper.
package framebuffer_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2
  } cmd_e;

  typedef logic [1:0] buf_index_t;

  localparam logic [21:0] DEFAULT_STRIDE = 22'h40000;

  function automatic logic [21:0] base_of(input buf_index_t b, input logic [21:0] stride);
    logic [21:0] r;
    r = '0;
    if (b == 2'd1) r = stride;
    else if (b == 2'd2) r = stride << 1;
    return r;
  endfunction

endpackage

// File: rtl/triple_buffer_tracker.sv
// Owns the three buffer roles (read / write / ready) and the write arming flag.
// Outputs are post-event values so the scheduler can arbitrate on them in the same cycle.
module triple_buffer_tracker
  import framebuffer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_apply_write_start,
  input  logic       i_apply_read_start,
  input  logic       i_write_complete,
  input  logic       i_write_offset_nonzero,
  output buf_index_t o_write_buf,
  output buf_index_t o_read_buf,
  output logic       o_write_armed,
  output logic       o_drop
);

  buf_index_t r_read_buf, r_write_buf, r_ready_buf;
  logic       r_ready_valid, r_write_armed;

  buf_index_t w_free_buf;
  logic       w_drop;
  logic       w_take_ready;

  // Lowest buffer that is neither being displayed nor holding the ready frame.
  always_comb begin
    w_free_buf = 2'd2;
    if (r_read_buf != 2'd0 && r_ready_buf != 2'd0) w_free_buf = 2'd0;
    else if (r_read_buf != 2'd1 && r_ready_buf != 2'd1) w_free_buf = 2'd1;
  end

  assign w_drop       = i_apply_write_start & r_write_armed & i_write_offset_nonzero;
  assign w_take_ready = i_apply_read_start & r_ready_valid;

  assign o_write_buf   = (i_apply_write_start && !w_drop) ? w_free_buf : r_write_buf;
  assign o_read_buf    = w_take_ready ? r_ready_buf : r_read_buf;
  assign o_write_armed = i_apply_write_start | r_write_armed;
  assign o_drop        = w_drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_read_buf    <= 2'd0;
      r_write_buf   <= 2'd1;
      r_ready_buf   <= 2'd2;
      r_ready_valid <= 1'b0;
      r_write_armed <= 1'b0;
    end else begin
      r_write_buf   <= o_write_buf;
      r_read_buf    <= o_read_buf;
      r_write_armed <= i_write_complete ? 1'b0 : o_write_armed;
      if (w_take_ready) r_ready_valid <= 1'b0;
      if (i_write_complete) begin
        r_ready_buf   <= r_write_buf;
        r_ready_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/framebuffer_scheduler.sv
// Arbitrates the SDRAM command port between camera write bursts and display read
// bursts. The FSM state is the controller command, so `command` exposes it directly.
module framebuffer_scheduler
  import framebuffer_pkg::*;
#(
  parameter int          BURST_LENGTH = 8,
  parameter int          FRAME_WORDS  = 153600,
  parameter logic [21:0] FRAME_STRIDE = DEFAULT_STRIDE,
  parameter int          LEVEL_WIDTH  = 5,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic                   sdram_clk,
  input  logic                   reset_n,
  input  logic [LEVEL_WIDTH-1:0] write_used,
  output logic                   write_pop,
  input  logic                   write_frame_start,
  input  logic [LEVEL_WIDTH-1:0] read_free,
  output logic                   read_push,
  input  logic                   read_frame_start,
  output logic [1:0]             command,
  output logic [21:0]            data_address,
  input  logic                   data_write_done,
  input  logic                   data_read_valid,
  output logic                   frame_dropped
);

  localparam int                   SW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]        STREAK_MX = SW'(STARVE_LIMIT);
  localparam logic [3:0]           BEAT_LAST = 4'(BURST_LENGTH - 1);
  localparam logic [LEVEL_WIDTH-1:0] BL_LVL  = LEVEL_WIDTH'(BURST_LENGTH);
  localparam logic [21:0]          BL_OFF    = 22'(BURST_LENGTH);
  localparam logic [21:0]          FRAME_OFF = 22'(FRAME_WORDS);

  // Handshake: the controller raises data_write_done / data_read_valid once per
  // word of the active burst; each is accepted in the cycle it is high (no stall).
  cmd_e        r_state, w_state_nxt;
  logic [3:0]  r_beat, w_beat_nxt;
  logic [21:0] r_woff, r_roff, r_addr;
  logic [21:0] w_woff_nxt, w_roff_nxt, w_addr_nxt;
  logic [SW-1:0] r_streak, w_streak_nxt;
  logic        r_pend_w, r_pend_r, r_drop;
  logic        w_idle, w_apply_w, w_apply_r, w_write_complete;
  logic        w_w_elig, w_r_elig, w_armed, w_drop;
  buf_index_t  w_write_buf, w_read_buf;

  assign w_idle    = (r_state == CMD_IDLE);
  assign w_apply_w = w_idle & (r_pend_w | write_frame_start);
  assign w_apply_r = w_idle & (r_pend_r | read_frame_start);

  triple_buffer_tracker u_tracker (
    .clk                    (sdram_clk),
    .rst_n                  (reset_n),
    .i_apply_write_start    (w_apply_w),
    .i_apply_read_start     (w_apply_r),
    .i_write_complete       (w_write_complete),
    .i_write_offset_nonzero (r_woff != 22'd0),
    .o_write_buf            (w_write_buf),
    .o_read_buf             (w_read_buf),
    .o_write_armed          (w_armed),
    .o_drop                 (w_drop)
  );

  assign w_w_elig = w_armed & (write_used >= BL_LVL);
  assign w_r_elig = (read_free >= BL_LVL);

  always_comb begin
    w_state_nxt      = r_state;
    w_beat_nxt       = r_beat;
    w_woff_nxt       = w_apply_w ? 22'd0 : r_woff;
    w_roff_nxt       = w_apply_r ? 22'd0 : r_roff;
    w_addr_nxt       = r_addr;
    w_streak_nxt     = r_streak;
    w_write_complete = 1'b0;
    unique case (r_state)
      CMD_IDLE: begin
        w_beat_nxt = 4'd0;
        // Read wins unless the writer has already been passed over STARVE_LIMIT times.
        if (w_w_elig && (r_streak == STREAK_MX || !w_r_elig)) begin
          w_state_nxt  = CMD_WRITE;
          w_addr_nxt   = base_of(w_write_buf, FRAME_STRIDE) + w_woff_nxt;
          w_streak_nxt = '0;
        end else if (w_r_elig) begin
          w_state_nxt = CMD_READ;
          w_addr_nxt  = base_of(w_read_buf, FRAME_STRIDE) + w_roff_nxt;
          if (w_w_elig) w_streak_nxt = r_streak + SW'(1);
        end
      end
      CMD_WRITE: begin
        if (data_write_done) begin
          if (r_beat == BEAT_LAST) begin
            w_state_nxt      = CMD_IDLE;
            w_woff_nxt       = r_woff + BL_OFF;
            w_write_complete = (r_woff + BL_OFF == FRAME_OFF);
          end else begin
            w_beat_nxt = r_beat + 4'd1;
          end
        end
      end
      CMD_READ: begin
        if (data_read_valid) begin
          if (r_beat == BEAT_LAST) begin
            w_state_nxt = CMD_IDLE;
            w_roff_nxt  = (r_roff + BL_OFF == FRAME_OFF) ? 22'd0 : r_roff + BL_OFF;
          end else begin
            w_beat_nxt = r_beat + 4'd1;
          end
        end
      end
      default: w_state_nxt = CMD_IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk) begin
    if (!reset_n) begin
      r_state  <= CMD_IDLE;
      r_beat   <= 4'd0;
      r_woff   <= 22'd0;
      r_roff   <= 22'd0;
      r_addr   <= 22'd0;
      r_streak <= '0;
      r_pend_w <= 1'b0;
      r_pend_r <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_beat   <= w_beat_nxt;
      r_woff   <= w_woff_nxt;
      r_roff   <= w_roff_nxt;
      r_addr   <= w_addr_nxt;
      r_streak <= w_streak_nxt;
      r_pend_w <= (r_pend_w | write_frame_start) & ~w_idle;
      r_pend_r <= (r_pend_r | read_frame_start) & ~w_idle;
      r_drop   <= w_drop;
    end
  end

  // Unarmed camera data has no frame to land in, so it is drained without a command.
  assign write_pop     = ((r_state == CMD_WRITE) & data_write_done) |
                         (~w_armed & (write_used != '0));
  assign read_push     = (r_state == CMD_READ) & data_read_valid;
  assign command       = r_state;
  assign data_address  = r_addr;
  assign frame_dropped = r_drop;

endmodule

// File: tb/tb_framebuffer_scheduler.sv
// Directed scenarios against a small SDRAM-controller and FIFO-level model;
// expected bursts {command, address} are queued and compared at each burst start.
module tb_framebuffer_scheduler;

  localparam int BL = 8;

  logic        sdram_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  write_used = '0;
  logic [4:0]  read_free = '0;
  logic        write_frame_start = 1'b0;
  logic        read_frame_start = 1'b0;
  logic        data_write_done = 1'b0;
  logic        data_read_valid = 1'b0;
  logic        write_pop, read_push, frame_dropped;
  logic [1:0]  command;
  logic [21:0] data_address;

  framebuffer_scheduler #(
    .BURST_LENGTH (BL),
    .FRAME_WORDS  (64),
    .FRAME_STRIDE (22'h40000),
    .LEVEL_WIDTH  (5),
    .STARVE_LIMIT (4)
  ) dut (
    .sdram_clk         (sdram_clk),
    .reset_n           (reset_n),
    .write_used        (write_used),
    .write_pop         (write_pop),
    .write_frame_start (write_frame_start),
    .read_free         (read_free),
    .read_push         (read_push),
    .read_frame_start  (read_frame_start),
    .command           (command),
    .data_address      (data_address),
    .data_write_done   (data_write_done),
    .data_read_valid   (data_read_valid),
    .frame_dropped     (frame_dropped)
  );

  // clock / reset
  always #5 sdram_clk = ~sdram_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [23:0] exp_q[$];
  int n_checks = 0, n_fail = 0;
  int n_pops = 0, n_push = 0, n_drop = 0, n_bursts = 0;
  logic        wr_hold = 1'b0;
  logic        pend_pop = 1'b0;
  int          beats_sent = 0, beats_seen = 0;
  logic [1:0]  prev_cmd = 2'd0;
  logic [21:0] start_addr = '0, last_addr = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // controller + FIFO level model, then output sampling just before the next edge
  always begin
    @(negedge sdram_clk);
    if (pend_pop && !wr_hold && write_used != 5'd0) write_used = write_used - 5'd1;
    pend_pop = 1'b0;
    if (command == 2'd0) begin
      beats_sent = 0;
      data_write_done = 1'b0;
      data_read_valid = 1'b0;
    end else if (beats_sent < BL && $urandom_range(0, 3) != 0) begin
      beats_sent++;
      data_write_done = (command == 2'd1);
      data_read_valid = (command == 2'd2);
    end else begin
      data_write_done = 1'b0;
      data_read_valid = 1'b0;
    end
    #3;
    if (!reset_n) begin
      prev_cmd = 2'd0;
    end else begin
      pend_pop = write_pop;
      if (write_pop) n_pops++;
      if (read_push) n_push++;
      if (frame_dropped) n_drop++;
      if (command != 2'd0) begin
        if (prev_cmd == 2'd0) begin
          n_bursts++;
          if (exp_q.size() == 0) check_eq("burst_unexpected", {command, data_address}, 24'h0);
          else check_eq("burst_cmd_addr", {command, data_address}, exp_q.pop_front());
          start_addr = data_address;
          beats_seen = 0;
        end
        if ((command == 2'd1 && write_pop) || (command == 2'd2 && read_push)) beats_seen++;
        last_addr = data_address;
      end else if (prev_cmd != 2'd0) begin
        check_eq("burst_beats", beats_seen, BL);
        check_eq("addr_held", last_addr, start_addr);
      end
      prev_cmd = command;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(negedge sdram_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    write_used = '0;
    read_free = '0;
    write_frame_start = 1'b0;
    read_frame_start = 1'b0;
    wr_hold = 1'b0;
    exp_q.delete();
    step(3);
    reset_n = 1'b1;
    n_pops = 0; n_push = 0; n_drop = 0; n_bursts = 0;
  endtask

  task automatic pulse_wfs();
    write_frame_start = 1'b1;
    step(1);
    write_frame_start = 1'b0;
  endtask

  task automatic pulse_rfs();
    read_frame_start = 1'b1;
    step(1);
    read_frame_start = 1'b0;
  endtask

  task automatic wait_started();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      step(1);
      cyc++;
    end
    if (cyc >= 3000) check_eq("start_timeout", 32'(exp_q.size()), 0);
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || command != 2'd0) && cyc < 3000) begin
      step(1);
      cyc++;
    end
    if (cyc >= 3000) check_eq("drain_timeout", {22'h0, command, 8'(exp_q.size())}, 0);
    step(4);
  endtask

  initial begin
    // reset values, then a single write burst into buffer 1
    do_reset();
    step(1);
    check_eq("rst_command", command, 0);
    check_eq("rst_address", data_address, 0);
    check_eq("rst_write_pop", write_pop, 0);
    check_eq("rst_read_push", read_push, 0);
    check_eq("rst_dropped", frame_dropped, 0);
    pulse_wfs();
    write_used = 5'd8;
    exp_q.push_back({2'd1, 22'h40000});
    wait_drain();
    check_eq("s1_pops", n_pops, 8);
    check_eq("s1_cmd_idle", command, 0);
    check_eq("s1_bursts", n_bursts, 1);

    // starvation limit: four reads, one write, then reads again
    do_reset();
    pulse_wfs();
    wr_hold = 1'b1;
    write_used = 5'd8;
    read_free = 5'd16;
    for (int i = 0; i < 4; i++) exp_q.push_back({2'd2, 22'(8 * i)});
    exp_q.push_back({2'd1, 22'h40000});
    exp_q.push_back({2'd2, 22'd32});
    wait_started();
    read_free = '0;
    write_used = '0;
    wait_drain();
    check_eq("s2_pops", n_pops, 8);
    check_eq("s2_pushes", n_push, 40);

    // full frame into buffer 1, hand it to the display, next frame goes to buffer 0
    do_reset();
    pulse_wfs();
    wr_hold = 1'b1;
    write_used = 5'd8;
    for (int i = 0; i < 8; i++) exp_q.push_back({2'd1, 22'h40000 + 22'(8 * i)});
    wait_started();
    write_used = '0;
    wait_drain();
    check_eq("s3_pops", n_pops, 64);
    pulse_rfs();
    read_free = 5'd8;
    exp_q.push_back({2'd2, 22'h40000});
    wait_started();
    read_free = '0;
    wait_drain();
    check_eq("s3_pushes", n_push, 8);
    pulse_wfs();
    write_used = 5'd8;
    exp_q.push_back({2'd1, 22'h0});
    wait_started();
    write_used = '0;
    wait_drain();

    // finish buffer 0, then swap displayed buffer while a read burst is in flight
    write_used = 5'd8;
    for (int i = 1; i < 8; i++) exp_q.push_back({2'd1, 22'(8 * i)});
    wait_started();
    write_used = '0;
    wait_drain();
    read_free = 5'd8;
    exp_q.push_back({2'd2, 22'h40008});
    wait_started();
    check_eq("s5_rfs_mid_burst", command, 2);
    pulse_rfs();
    exp_q.push_back({2'd2, 22'h0});
    wait_started();
    read_free = '0;
    wait_drain();
    check_eq("s5_dropped", n_drop, 0);

    // partial frame abandoned: drop pulse and restart at buffer base
    do_reset();
    pulse_wfs();
    wr_hold = 1'b1;
    write_used = 5'd8;
    exp_q.push_back({2'd1, 22'h40000});
    exp_q.push_back({2'd1, 22'h40008});
    wait_started();
    write_used = '0;
    wait_drain();
    check_eq("s4_no_drop_yet", n_drop, 0);
    pulse_wfs();
    step(3);
    check_eq("s4_drop_once", n_drop, 1);
    write_used = 5'd8;
    exp_q.push_back({2'd1, 22'h40000});
    wait_started();
    write_used = '0;
    wait_drain();
    check_eq("s4_drop_still_once", n_drop, 1);

    // unarmed flush: every waiting word is popped, no command issued
    do_reset();
    write_used = 5'd5;
    step(15);
    check_eq("s6_flush_pops", n_pops, 5);
    check_eq("s6_no_bursts", n_bursts, 0);
    check_eq("s6_cmd_idle", command, 0);

    // reset in the middle of a burst returns everything to reset values
    do_reset();
    pulse_wfs();
    wr_hold = 1'b1;
    write_used = 5'd8;
    exp_q.push_back({2'd1, 22'h40000});
    wait_started();
    step(2);
    do_reset();
    step(1);
    check_eq("s7_rst_command", command, 0);
    check_eq("s7_rst_address", data_address, 0);
    pulse_wfs();
    wr_hold = 1'b1;
    write_used = 5'd8;
    exp_q.push_back({2'd1, 22'h40000});
    wait_started();
    write_used = '0;
    wait_drain();
    check_eq("s7_pops", n_pops, 8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/framebuffer_scheduler.md
# framebuffer_scheduler

Sequences the single SDRAM controller command port between a camera write stream and a display read stream, one fixed-length burst at a time. Manages three frame buffers so the display never reads a partially written frame. Sits in the `sdram_clk` domain between the MIPI write FIFO, the pixel read FIFO and the SDRAM controller. Moves no pixel data: it drives controller commands, addresses and FIFO pop/push strobes only.

## Interface
Parameters:
- `BURST_LENGTH`, 8: words per burst. Must be a power of two, at most 8.
- `FRAME_WORDS`, 153600: 16-bit words per frame (640×480 RAW8). Must be a multiple of `BURST_LENGTH`.
- `FRAME_STRIDE`, 22'h40000: address distance between buffer bases. Buffer bases are 0, 1×, 2× stride.
- `LEVEL_WIDTH`, 5: width of the FIFO level inputs.
- `STARVE_LIMIT`, 4: maximum consecutive read bursts while a write is eligible.

Ports:
- `sdram_clk` in 1: sole clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `write_used` in `LEVEL_WIDTH`: words waiting in the write FIFO.
- `write_pop` out 1: acknowledge one write-FIFO word.
- `write_frame_start` in 1: one-cycle pulse, camera frame begins. Already synchronised to `sdram_clk`.
- `read_free` in `LEVEL_WIDTH`: free slots in the read FIFO.
- `read_push` out 1: push `data_read` into the read FIFO.
- `read_frame_start` in 1: one-cycle pulse, display frame begins.
- `command` out 2: 0 idle, 1 write, 2 read.
- `data_address` out 22: burst start address.
- `data_write_done` in 1: controller accepted one write word.
- `data_read_valid` in 1: controller returned one read word.
- `frame_dropped` out 1: one-cycle pulse, a partial camera frame was abandoned.

## Operation
- FSM states:
  - IDLE: evaluates eligibility and latched events.
  - WRITE: counts `data_write_done` to `BURST_LENGTH`.
  - READ: counts `data_read_valid` to `BURST_LENGTH`.
- Write eligible: `write_armed` set and `write_used >= BURST_LENGTH`.
- Read eligible: `read_free >= BURST_LENGTH`.
- Arbitration in IDLE:
  - Read has priority.
  - Exception: if `streak == STARVE_LIMIT` and write is eligible, grant write.
  - `streak` counts consecutive read grants made while write was eligible. It clears on any write grant.
- Write offset and read offset are each 22 bits and advance by `BURST_LENGTH` at the end of each burst of their type.
- `data_address` = base(buf) + offset. It is registered at grant and held for the whole burst.
- `write_pop` = `data_write_done` in WRITE. The controller takes data from the FIFO head (show-ahead).
- `read_push` = `data_read_valid` in READ.
- While `write_armed` is clear, `write_pop` is asserted every cycle that `write_used != 0`. This flushes camera data that has no frame. No SDRAM command is issued for it.
- Buffer indices:
  - Reset values: `read_buf` = 0, `write_buf` = 1, `ready_buf` = 2, `ready_valid` = 0, `write_armed` = 0.
- End of a write burst where the write offset reaches `FRAME_WORDS`:
  - `ready_buf` ← `write_buf`, `ready_valid` ← 1.
  - `write_armed` ← 0.
- `write_frame_start` (latched until IDLE):
  - If `write_armed` is set and the write offset is nonzero, pulse `frame_dropped` and restart the same buffer.
  - Otherwise `write_buf` ← lowest index not equal to `read_buf` or `ready_buf`.
  - In both cases the write offset ← 0 and `write_armed` ← 1.
- `read_frame_start` (latched until IDLE):
  - If `ready_valid` is set: `read_buf` ← `ready_buf`, `ready_valid` ← 0.
  - The read offset ← 0 in all cases.
- Read offset reaching `FRAME_WORDS` wraps to 0 and re-reads the same buffer.
- Invariant: `write_buf` never equals `read_buf` while `write_armed` is set.

## Timing
- Reset values: `command` 0, `data_address` 0, `write_pop` 0, `read_push` 0, `frame_dropped` 0, offsets 0, `streak` 0.
- Grant decision in IDLE; `command` becomes nonzero on the next cycle.
- `command` returns to 0 on the cycle after the `BURST_LENGTH`-th done/valid. Every pair of bursts has at least one IDLE cycle between them.
- Frame-start pulses arriving mid-burst are held in sticky latches and applied in the first IDLE cycle. Events are applied before arbitration in that cycle.
- When both frame-start latches are pending, write is applied first, then read.
- A write completion is registered at burst end and is visible to a `read_frame_start` applied in the following IDLE cycle.
- `reset_n` low mid-burst: all state returns to reset values on the next edge. The controller is reset alongside.

## Structure
- `framebuffer_pkg`:
  - command enum (IDLE/WRITE/READ = 0/1/2).
  - 2-bit `buf_index_t`.
  - `base_of(buf_index_t)` function.
- Sub-module `triple_buffer_tracker`:
  - Holds `read_buf`, `write_buf`, `ready_buf`, `ready_valid` and `write_armed`.
  - Applies the frame-start and completion rules.
  - Exposes the current indices to the scheduler FSM.

## Test plan
- Reset, then `write_frame_start`, then `write_used` = 8 with `read_free` = 0 → one write burst at address 22'h40000, then eight `write_pop` pulses, then `command` back to 0.
- `read_free` = 16 and `write_used` = 8 held constant → four read bursts, one write burst, then reads again. Read addresses are 0, 8, 16, 24, then 32.
- Write a full `FRAME_WORDS`, then pulse `read_frame_start` → next read address = 22'h40000. The following `write_frame_start` selects buffer 0.
- `write_frame_start` after 16 words written → `frame_dropped` pulses once and the next write address = buffer base + 0.
- `read_frame_start` pulsed during a read burst → burst completes at the old address and the next read starts at the new buffer's offset 0.
- `write_used` = 5 while not armed → five `write_pop` pulses and `command` stays 0.
